// File: rtl/bcd2bin.sv
// bcd2bin: serial reverse double-dabble converter.
// Turns NDIGIT packed BCD digits into an NBIT binary value, one result bit per
// clock cycle, LSB first. The serial bits appear on ser_out/ser_valid, and the
// full result is latched on bin_out when done pulses.
module bcd2bin #(
    parameter int NDIGIT = 2,
    parameter int NBIT   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NDIGIT*4-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [NBIT-1:0]       bin_out,
    output logic                  err,
    output logic                  ovf,
    output logic                  ser_out,
    output logic                  ser_valid
);

    localparam int W  = NDIGIT * 4;
    localparam int CW = $clog2(NBIT + 1);
    localparam logic [CW-1:0] LAST = CW'(NBIT - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [W-1:0]     work;      // remaining BCD value, halved each iteration
    logic [NBIT-1:0]  acc;       // binary bits collected so far, entering at the MSB
    logic [CW-1:0]    cnt;       // completed iterations

    logic [W+NBIT-1:0] cat;
    logic [W-1:0]      nxt_work;
    logic [NBIT-1:0]   nxt_acc;
    logic              bad_digit;

    // One iteration: shift {work,acc} right, then pull every digit >= 8 back by 3
    // so that each digit again holds a valid half of its decimal weight.
    always_comb begin
        // NOTE: every signal gets a value before any conditional update, so no latch is inferred.
        cat      = {work, acc} >> 1;
        nxt_acc  = cat[NBIT-1:0];
        nxt_work = cat[W+NBIT-1:NBIT];
        for (int i = 0; i < NDIGIT; i++) begin
            if (nxt_work[4*i +: 4] >= 4'd8)
                nxt_work[4*i +: 4] = nxt_work[4*i +: 4] - 4'd3;
        end
    end

    // Flag a request containing any non-decimal digit.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGIT; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    // Control FSM with registered outputs; the result registers change only
    // together with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            work      <= '0;
            acc       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bin_out   <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done      <= 1'b0;
            ser_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_digit) begin
                            err     <= 1'b1;
                            ovf     <= 1'b0;
                            bin_out <= '0;
                            done    <= 1'b1;
                        end else begin
                            work  <= bcd_in;
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= nxt_work;
                    acc       <= nxt_acc;
                    cnt       <= cnt + 1'b1;
                    ser_out   <= work[0];
                    ser_valid <= 1'b1;
                    if (cnt == LAST) begin
                        bin_out <= nxt_acc;
                        ovf     <= (nxt_work != '0);
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: directed-vector bench for bcd2bin in a 2-digit/7-bit and a
// 3-digit/8-bit configuration sharing one clock and reset.
module tb_bcd2bin;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 2-digit, 7-bit instance
    logic       start_a = 1'b0;
    logic [7:0] bcd_a   = '0;
    logic       busy_a, done_a, err_a, ovf_a, ser_a, sv_a;
    logic [6:0] bin_a;

    // 3-digit, 8-bit instance
    logic        start_b = 1'b0;
    logic [11:0] bcd_b   = '0;
    logic        busy_b, done_b, err_b, ovf_b, ser_b, sv_b;
    logic [7:0]  bin_b;

    bcd2bin #(.NDIGIT(2), .NBIT(7)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bcd_in(bcd_a),
        .busy(busy_a), .done(done_a), .bin_out(bin_a), .err(err_a),
        .ovf(ovf_a), .ser_out(ser_a), .ser_valid(sv_a)
    );

    bcd2bin #(.NDIGIT(3), .NBIT(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bcd_in(bcd_b),
        .busy(busy_b), .done(done_b), .bin_out(bin_b), .err(err_b),
        .ovf(ovf_b), .ser_out(ser_b), .ser_valid(sv_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Start one conversion on dut_a; return the serial bits, the edge count from
    // the accepting edge (counted as 1) to done high, and the number of valid bits.
    task automatic run_a(input logic [7:0] bcd, output logic [6:0] bits,
                         output int lat, output int nvalid);
        @(negedge clk);
        bcd_a   = bcd;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        bcd_a   = 8'h17;   // later input changes must not affect the result
        bits    = '0;
        lat     = 1;
        nvalid  = 0;
        while (!done_a && lat < 40) begin
            if (sv_a && nvalid < 7) begin
                bits[nvalid] = ser_a;
                nvalid++;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (sv_a && nvalid < 7) begin
            bits[nvalid] = ser_a;
            nvalid++;
        end
    endtask

    task automatic run_b(input logic [11:0] bcd, output int lat);
        @(negedge clk);
        bcd_b   = bcd;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        lat     = 1;
        while (!done_b && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    logic [6:0] bits;
    int lat, nv, ndone;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_bin",   32'(bin_a),   32'd0);
        check("rst_err",   32'(err_a),   32'd0);
        check("rst_ovf",   32'(ovf_a),   32'd0);
        check("rst_ser",   32'(ser_a),   32'd0);
        check("rst_sv",    32'(sv_a),    32'd0);
        check("rst_bin_b", 32'(bin_b),   32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy_a), 32'd0);

        // T1: 42
        run_a(8'h42, bits, lat, nv);
        check("t1_lat",   32'(lat),   32'd8);
        check("t1_nser",  32'(nv),    32'd7);
        check("t1_bits",  32'(bits),  32'b0101010);
        check("t1_bin",   32'(bin_a), 32'd42);
        check("t1_err",   32'(err_a), 32'd0);
        check("t1_ovf",   32'(ovf_a), 32'd0);
        check("t1_busy",  32'(busy_a), 32'd0);
        @(negedge clk);
        check("t1_pulse", 32'(done_a), 32'd0);
        check("t1_svlow", 32'(sv_a),   32'd0);
        check("t1_hold",  32'(bin_a),  32'd42);

        // T2: 99
        run_a(8'h99, bits, lat, nv);
        check("t2_bits", 32'(bits),  32'b1100011);
        check("t2_bin",  32'(bin_a), 32'd99);
        check("t2_ovf",  32'(ovf_a), 32'd0);

        // T3: 00 then a non-decimal request
        run_a(8'h00, bits, lat, nv);
        check("t3_bin",  32'(bin_a), 32'd0);
        check("t3_ovf",  32'(ovf_a), 32'd0);
        check("t3_nser", 32'(nv),    32'd7);
        run_a(8'h5A, bits, lat, nv);
        check("t3e_lat",  32'(lat),   32'd1);
        check("t3e_err",  32'(err_a), 32'd1);
        check("t3e_bin",  32'(bin_a), 32'd0);
        check("t3e_nser", 32'(nv),    32'd0);
        check("t3e_busy", 32'(busy_a), 32'd0);
        run_a(8'h07, bits, lat, nv);
        check("t3_errclr", 32'(err_a), 32'd0);
        check("t3_bin7",   32'(bin_a), 32'd7);

        // T4: 3 digits, 8 bits
        run_b(12'h300, lat);
        check("t4a_lat", 32'(lat),   32'd9);
        check("t4a_bin", 32'(bin_b), 32'd44);
        check("t4a_ovf", 32'(ovf_b), 32'd1);
        run_b(12'h255, lat);
        check("t4b_bin", 32'(bin_b), 32'd255);
        check("t4b_ovf", 32'(ovf_b), 32'd0);
        run_b(12'h999, lat);
        check("t4c_bin", 32'(bin_b), 32'd231);
        check("t4c_ovf", 32'(ovf_b), 32'd1);

        // T5a: extra start pulses during a conversion are ignored
        @(negedge clk);
        bcd_a   = 8'h63;
        start_a = 1'b1;
        ndone   = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            start_a = (c == 2 || c == 4);   // high before edges 3 and 5
            if (c == 2) bcd_a = 8'h11;
            if (c == 4) check("t5_stable", 32'(bin_a), 32'd7);
            if (done_a) ndone++;
        end
        check("t5_ndone", 32'(ndone), 32'd1);
        check("t5_bin",   32'(bin_a), 32'd63);

        // T5b: start held through done starts the next conversion in the done cycle
        @(negedge clk);
        bcd_a   = 8'h42;
        start_a = 1'b1;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("t5b_done", 32'(done_a), 32'd1);
        check("t5b_bin",  32'(bin_a),  32'd42);
        bcd_a = 8'h85;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        check("t5b_busy2", 32'(busy_a), 32'd1);
        lat = 2;
        while (!done_a && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("t5b_lat2", 32'(lat),   32'd9);
        check("t5b_bin2", 32'(bin_a), 32'd85);

        // T6: reset mid-conversion
        @(negedge clk);
        bcd_a   = 8'h42;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("t6_busy", 32'(busy_a), 32'd0);
        check("t6_done", 32'(done_a), 32'd0);
        check("t6_sv",   32'(sv_a),   32'd0);
        check("t6_bin",  32'(bin_a),  32'd0);
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a || busy_a) ndone++;
        end
        check("t6_idle",   32'(ndone), 32'd0);
        check("t6_binrst", 32'(bin_a), 32'd0);
        run_a(8'h13, bits, lat, nv);
        check("t6_after", 32'(bin_a), 32'd13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
